// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential Vedic multiplier.
package vedic_pkg;

  // Top-level control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Step indices: which half of each operand feeds the core.
  // Bit 0 selects the high half of a, bit 1 the high half of b.
  localparam logic [1:0] STEP0 = 2'd0; // aL * bL
  localparam logic [1:0] STEP1 = 2'd1; // aH * bL
  localparam logic [1:0] STEP2 = 2'd2; // aL * bH
  localparam logic [1:0] STEP3 = 2'd3; // aH * bH

  // Shift constants in units of the core width N/2:
  // SH0 = 0, SH1 = SH2 = N/2, SH3 = N.
  localparam int unsigned SH0_HALVES = 0;
  localparam int unsigned SH1_HALVES = 1;
  localparam int unsigned SH2_HALVES = 1;
  localparam int unsigned SH3_HALVES = 2;

  // Left shift applied to the partial product of a given step.
  function automatic int unsigned step_shift(input logic [1:0] step,
                                             input int unsigned half);
    case (step)
      STEP0:   return SH0_HALVES * half;
      STEP1:   return SH1_HALVES * half;
      STEP2:   return SH2_HALVES * half;
      default: return SH3_HALVES * half;
    endcase
  endfunction

endpackage

// File: rtl/vedic_core.sv
// Combinational W x W unsigned Vedic multiplier (urdhva-tiryagbhyam).
// Operands are split into 2-bit digits; every digit pair is multiplied by
// a 2x2 Vedic cell and the vertical/crosswise products of each digit
// column are summed at their column weight.
module vedic_core #(
  parameter int W = 4
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);

  // Odd widths are padded with a zero bit so both operands split into whole digits.
  localparam int W2 = W + (W % 2);
  localparam int ND = W2 / 2;

  logic [W2-1:0]   w_a_pad;
  logic [W2-1:0]   w_b_pad;
  logic [2*W2-1:0] w_sum;

  // 2x2 Vedic cell: vertical bits give p0 and the p2/p3 pair, the
  // crosswise pair gives p1 and a carry into p2.
  function automatic logic [3:0] cell2x2(input logic [1:0] x, input logic [1:0] y);
    logic t1, t2, t3, c1;
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    t3 = x[1] & y[1];
    c1 = t1 & t2;
    return {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
  endfunction

  // Sum all digit-pair products at weight 4^(i+j).
  // NOTE: every variable written in a combinational block gets a value
  // before any branch or loop, so no path can leave it holding state (latch).
  always_comb begin
    logic [2*W2-1:0] term;
    w_a_pad = '0;
    w_b_pad = '0;
    w_sum   = '0;
    term    = '0;
    w_a_pad[W-1:0] = i_a;
    w_b_pad[W-1:0] = i_b;
    for (int i = 0; i < ND; i++) begin
      for (int j = 0; j < ND; j++) begin
        term      = '0;
        term[3:0] = cell2x2(w_a_pad[2*i +: 2], w_b_pad[2*j +: 2]);
        w_sum     = w_sum + (term << (2 * (i + j)));
      end
    end
  end

  assign o_p = w_sum[2*W-1:0];

endmodule

// File: rtl/vedic_mul_seq.sv
// Sequential N x N unsigned multiplier: one N/2 x N/2 Vedic core reused
// over four cycles, partial products shifted and accumulated into 2N bits.
// N must be even and at least 4.
module vedic_mul_seq
  import vedic_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int H = N / 2;
  localparam int P = 2 * N;

  state_e       r_state;
  state_e       w_state_nxt;
  logic [1:0]   r_step;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [P-1:0] r_acc;

  logic         w_accept;
  logic [H-1:0] w_core_a;
  logic [H-1:0] w_core_b;
  logic [N-1:0] w_pp;
  logic [P-1:0] w_pp_ext;

  assign w_accept = (r_state == ST_IDLE) && in_valid;

  // Step counter picks the operand halves presented to the shared core.
  always_comb begin
    w_core_a = r_step[0] ? r_a[N-1:H] : r_a[H-1:0];
    w_core_b = r_step[1] ? r_b[N-1:H] : r_b[H-1:0];
  end

  vedic_core #(.W(H)) u_core (
    .i_a (w_core_a),
    .i_b (w_core_b),
    .o_p (w_pp)
  );

  // Zero-extend the partial product and move it to its step's weight.
  assign w_pp_ext = {{N{1'b0}}, w_pp} << step_shift(r_step, H);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_state_nxt = ST_MUL;
      end
      ST_MUL: begin
        busy = 1'b1;
        if (r_step == STEP3) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, step counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_step <= STEP0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_acc  <= '0;
      r_step <= STEP0;
    end else if (r_state == ST_MUL) begin
      // Sum stays within (2^N-1)^2, so the 2N-bit add never carries out.
      r_acc  <= r_acc + w_pp_ext;
      r_step <= r_step + 2'd1;
    end
  end

  assign product = r_acc;

endmodule

// File: tb/tb_vedic_mul_seq.sv
// Self-checking bench for vedic_mul_seq: table-driven directed vectors,
// reset/stall/stream sequences and random operands, with a scoreboard
// queue filled at accept time and drained at the result handshake.
module tb_vedic_mul_seq;

  localparam int N = 8;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] exp;
    int             stall;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic           busy;

  int             n_checks = 0;
  int             n_errors = 0;
  int             cyc = 0;
  logic [2*N-1:0] exp_q[$];

  vedic_mul_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result monitor: a product leaves on the edge after a negedge where
  // out_valid && out_ready; inputs only change #1 after posedges.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(product), 32'hDEAD_BEEF);
      end else begin
        check("product", 32'(product), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  // One full operation: accept, four accumulate cycles, optional stall
  // in DONE, handshake, back to IDLE. Operands are scrambled and in_valid
  // pulsed after the accept edge; neither may affect the result.
  task automatic run_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b,
                        input logic [2*N-1:0] exp, input int stall);
    bit ok;
    int lat;
    out_ready = (stall == 0);
    wait_ready(ok);
    if (!ok) return;
    a        = op_a;
    b        = op_b;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    tick(); // accept edge E0
    a   = N'($urandom);
    b   = N'($urandom);
    lat = 0;
    while (!out_valid && lat < 16) begin
      check("in_ready_mul", 32'(in_ready), 32'd0);
      check("busy_mul", 32'(busy), 32'd1);
      if (lat == 2) in_valid = 1'b0;
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, 32'd4);
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_product", 32'(product), 32'(exp));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick(); // handshake edge
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t           vecs[7];
    logic [N-1:0]   sa[3];
    logic [N-1:0]   sb[3];
    int             t_acc[3];
    bit             ok;
    logic [N-1:0]   ra;
    logic [N-1:0]   rb;

    vecs[0] = '{a: 8'hFF, b: 8'hFF, exp: 16'hFE01, stall: 0};
    vecs[1] = '{a: 8'h12, b: 8'h34, exp: 16'h03A8, stall: 0};
    vecs[2] = '{a: 8'h00, b: 8'hA7, exp: 16'h0000, stall: 0};
    vecs[3] = '{a: 8'h80, b: 8'h02, exp: 16'h0100, stall: 3};
    vecs[4] = '{a: 8'h03, b: 8'h05, exp: 16'h000F, stall: 0};
    vecs[5] = '{a: 8'h01, b: 8'hFF, exp: 16'h00FF, stall: 1};
    vecs[6] = '{a: 8'hF0, b: 8'h0F, exp: 16'h0E10, stall: 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall);
    end

    // Reset while step==2 of 0xF0 * 0x0F: the op is discarded at once.
    out_ready = 1'b1;
    wait_ready(ok);
    a        = 8'hF0;
    b        = 8'h0F;
    in_valid = 1'b1;
    exp_q.push_back(16'h0E10);
    tick(); // accept
    in_valid = 1'b0;
    tick(); // step 0 done
    tick(); // step 1 done, now at step 2
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_product", 32'(product), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    run_op(8'h03, 8'h05, 16'h000F, 0);

    // Stream: in_valid held high. Each op spends four MUL cycles, one DONE
    // cycle and one IDLE cycle, so accepts land six edges apart.
    sa[0] = 8'h11; sb[0] = 8'h22;
    sa[1] = 8'hC3; sb[1] = 8'h5A;
    sa[2] = 8'h7F; sb[2] = 8'h81;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = sa[k];
      b = sb[k];
      wait_ready(ok);
      exp_q.push_back(16'(sa[k]) * 16'(sb[k]));
      t_acc[k] = cyc;
      tick();
    end
    in_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      check("stream_spacing", t_acc[k] - t_acc[k-1], 32'd6);
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    check("stream_drained", exp_q.size(), 32'd0);
    tick();

    // Random operands against the bench's own multiply.
    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      run_op(ra, rb, 16'(ra) * 16'(rb), (i % 50 == 0) ? 2 : 0);
    end

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
